// File: rtl/mips_ctrl_pkg.sv
// Shared decode-stage definitions: opcodes, control bundle layout and the
// hazard FSM state type used by the decoder and the ID/EX control register.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_NOP   = 6'b100000;

  localparam int WB_W = 2;
  localparam int M_W  = 3;
  localparam int EX_W = 4;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int M_BRANCH    = 2;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;
  localparam int EX_REGDST   = 3;
  localparam int EX_ALUOP1   = 2;
  localparam int EX_ALUOP0   = 1;
  localparam int EX_ALUSRC   = 0;

  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
    logic [EX_W-1:0] ex;
    logic            jump;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef enum logic {RUN, STALL} state_e;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational opcode -> control bundle table. Unknown opcodes decode
// to an all-zero bundle so downstream never sees X.
module ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  output ctrl_t      ctrl_o,
  output logic       uses_rt_o
);

  // NOTE: every output gets a default before the case; a path that leaves an
  // output unassigned in always_comb would infer a latch.
  always_comb begin
    ctrl_o    = CTRL_BUBBLE;
    uses_rt_o = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        ctrl_o.ex[EX_REGDST]   = 1'b1;
        ctrl_o.ex[EX_ALUOP1]   = 1'b1;
        ctrl_o.wb[WB_REGWRITE] = 1'b1;
        uses_rt_o              = 1'b1;
      end
      OP_LW: begin
        ctrl_o.ex[EX_ALUSRC]   = 1'b1;
        ctrl_o.m[M_MEMREAD]    = 1'b1;
        ctrl_o.wb[WB_REGWRITE] = 1'b1;
        ctrl_o.wb[WB_MEMTOREG] = 1'b1;
      end
      OP_SW: begin
        ctrl_o.ex[EX_ALUSRC]  = 1'b1;
        ctrl_o.m[M_MEMWRITE]  = 1'b1;
        uses_rt_o             = 1'b1;
      end
      OP_BEQ: begin
        ctrl_o.ex[EX_ALUOP0] = 1'b1;
        ctrl_o.m[M_BRANCH]   = 1'b1;
        uses_rt_o            = 1'b1;
      end
      OP_ADDI: begin
        ctrl_o.ex[EX_ALUSRC]   = 1'b1;
        ctrl_o.wb[WB_REGWRITE] = 1'b1;
      end
      OP_J:    ctrl_o.jump = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/id_ctrl_hazard.sv
// Decode-stage control: decodes IF/ID, registers the ID/EX control fields,
// inserts STALL_CYCLES bubbles on load-use hazards and squashes on flush.
module id_ctrl_hazard
  import mips_ctrl_pkg::*;
#(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_id_instr,
  input  logic             flush,
  output logic [WB_W-1:0]  id_ex_wb,
  output logic [M_W-1:0]   id_ex_m,
  output logic [EX_W-1:0]  id_ex_ex,
  output logic             id_ex_jump,
  output logic             pc_write,
  output logic             if_id_write,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic [5:0] opcode;
  logic [4:0] rs, rt;
  ctrl_t      dec_ctrl;
  logic       uses_rt;
  logic       hazard;
  logic       stall_now;
  logic       unused_instr_bits;

  state_e           state_q, state_d;
  logic [1:0]       scnt_q, scnt_d;
  logic [4:0]       ex_rt_q, ex_rt_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign opcode            = if_id_instr[31:26];
  assign rs                = if_id_instr[25:21];
  assign rt                = if_id_instr[20:16];
  assign unused_instr_bits = ^if_id_instr[15:0];

  ctrl_decode u_decode (
    .opcode_i  (opcode),
    .ctrl_o    (dec_ctrl),
    .uses_rt_o (uses_rt)
  );

  // Only an issued lw sets MemRead, so this compares against the load's target.
  assign hazard = (state_q == RUN) && ctrl_q.m[M_MEMREAD] && (ex_rt_q != 5'd0) &&
                  ((ex_rt_q == rs) || (uses_rt && (ex_rt_q == rt)));

  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    ctrl_d    = CTRL_BUBBLE;
    ex_rt_d   = 5'd0;
    cnt_d     = cnt_q;
    stall_now = 1'b0;
    if (flush) begin
      state_d = RUN;
      scnt_d  = 2'd0;
    end else if (state_q == STALL) begin
      stall_now = 1'b1;
      scnt_d    = scnt_q - 2'd1;
      if (scnt_q == 2'd1) state_d = RUN;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else if (hazard) begin
      stall_now = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      if (STALL_CYCLES > 1) begin
        state_d = STALL;
        scnt_d  = 2'(STALL_CYCLES - 1);
      end
    end else begin
      ctrl_d  = dec_ctrl;
      ex_rt_d = rt;
    end
  end

  // Reset forces the write enables high so fetch is never frozen by stale state.
  assign pc_write    = rst | ~stall_now;
  assign if_id_write = rst | ~stall_now;

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values; reset is synchronous, hence only clk in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      scnt_q  <= 2'd0;
      ex_rt_q <= 5'd0;
      ctrl_q  <= CTRL_BUBBLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      ex_rt_q <= ex_rt_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign id_ex_wb   = ctrl_q.wb;
  assign id_ex_m    = ctrl_q.m;
  assign id_ex_ex   = ctrl_q.ex;
  assign id_ex_jump = ctrl_q.jump;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ctrl_hazard.sv
// Scoreboard bench: three configurations of id_ctrl_hazard, each fed by a
// fetch model, checked against a load-use reference model every cycle.
module tb_id_ctrl_hazard;

  localparam int N_CYCLES = 1500;
  localparam int DIR_LEN  = 47;

  typedef struct {
    logic [9:0]  ctrl;
    int unsigned cnt;
  } exp_reg_t;

  logic clk;
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Control bundles straight from the opcode table: {WB, M, EX, jump}.
  function automatic logic [9:0] ref_decode(logic [5:0] op);
    case (op)
      6'b000000: return {2'b10, 3'b000, 4'b1100, 1'b0};
      6'b100011: return {2'b11, 3'b010, 4'b0001, 1'b0};
      6'b101011: return {2'b00, 3'b001, 4'b0001, 1'b0};
      6'b000100: return {2'b00, 3'b100, 4'b0010, 1'b0};
      6'b001000: return {2'b10, 3'b000, 4'b0001, 1'b0};
      6'b000010: return {2'b00, 3'b000, 4'b0000, 1'b1};
      default:   return 10'b0;
    endcase
  endfunction

  // Directed cycles {rst, flush, instr}; instr only matters when fetch advances.
  function automatic logic [33:0] dir_stim(int i);
    case (i)
      0, 1:   return {2'b10, 32'h80000000};
      2:      return {2'b00, 32'h010A4820};
      3, 8, 10, 14, 21, 26: return {2'b00, 32'h8C080000};
      4, 22, 27: return {2'b00, 32'h010A4820};
      9:      return {2'b00, 32'h01204820};
      11:     return {2'b00, 32'h8C090000};
      12:     return {2'b00, 32'h8C000000};
      13:     return {2'b00, 32'h000A4820};
      15:     return {2'b00, 32'h8D090000};
      16:     return {2'b00, 32'h012A4020};
      23:     return {2'b01, 32'h80000000};
      29:     return {2'b10, 32'h80000000};
      31:     return {2'b00, 32'hAC080000};
      32:     return {2'b00, 32'hFC000000};
      33:     return {2'b00, 32'h08000000};
      34:     return {2'b00, 32'h11090000};
      35:     return {2'b00, 32'h21090001};
      default: begin
        if (i >= 36 && i < 46) return (i % 2 == 0) ? {2'b00, 32'h8C080000} : {2'b00, 32'h010A4820};
        return {2'b00, 32'h80000000};
      end
    endcase
  endfunction

  function automatic logic [33:0] rand_stim();
    logic [5:0] op;
    logic       r, f;
    case ($urandom_range(0, 7))
      0: op = 6'b000000;
      1: op = 6'b100011;
      2: op = 6'b100011;
      3: op = 6'b101011;
      4: op = 6'b000100;
      5: op = 6'b001000;
      6: op = 6'b000010;
      default: op = 6'($urandom_range(0, 63));
    endcase
    r = ($urandom_range(0, 199) == 0);
    f = ($urandom_range(0, 11) == 0);
    return {r, f, op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom())};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int S  = (g == 1) ? 3 : ((g == 2) ? 2 : 1);
    localparam int CW = (g == 2) ? 2 : 16;

    logic          rst, flush;
    logic [31:0]   instr;
    logic [1:0]    wb;
    logic [2:0]    m;
    logic [3:0]    ex;
    logic          jump, pcw, ifw;
    logic [CW-1:0] cnt;
    logic          done;

    exp_reg_t reg_q[$];
    bit       comb_q[$];

    id_ctrl_hazard #(.STALL_CYCLES(S), .CNT_W(CW)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .if_id_instr (instr),
      .flush       (flush),
      .id_ex_wb    (wb),
      .id_ex_m     (m),
      .id_ex_ex    (ex),
      .id_ex_jump  (jump),
      .pc_write    (pcw),
      .if_id_write (ifw),
      .bubble_cnt  (cnt)
    );

    // Driver + reference model: tracks the last issued load target and the
    // number of bubbles still owed, and holds the fetched word while stalled.
    initial begin : drive
      logic [9:0]  m_ctrl;
      int unsigned m_cnt, cmax;
      int          last_ld, stall_left;
      logic        prev_pcw, exp_pcw, use_rt;
      logic [31:0] cur;
      logic [33:0] st;
      int          rs_f, rt_f;
      m_ctrl = '0; m_cnt = 0; last_ld = 0; stall_left = 0;
      prev_pcw = 1'b1; cur = 32'h80000000;
      cmax = (1 << CW) - 1;
      done = 1'b0; rst = 1'b1; flush = 1'b0; instr = cur;
      for (int k = 0; k < N_CYCLES; k++) begin
        @(posedge clk); #1;
        reg_q.push_back('{m_ctrl, m_cnt});
        st = (k < DIR_LEN) ? dir_stim(k) : rand_stim();
        if (prev_pcw) cur = st[31:0];
        rst = st[33]; flush = st[32]; instr = cur;
        rs_f   = int'(cur[25:21]);
        rt_f   = int'(cur[20:16]);
        use_rt = (cur[31:26] == 6'b000000) || (cur[31:26] == 6'b101011) ||
                 (cur[31:26] == 6'b000100);
        if (rst) begin
          exp_pcw = 1'b1; m_ctrl = '0; m_cnt = 0; last_ld = 0; stall_left = 0;
        end else if (flush) begin
          exp_pcw = 1'b1; m_ctrl = '0; last_ld = 0; stall_left = 0;
        end else if (stall_left > 0) begin
          exp_pcw = 1'b0; m_ctrl = '0; last_ld = 0; stall_left--;
          if (m_cnt < cmax) m_cnt++;
        end else if (last_ld != 0 && (rs_f == last_ld || (use_rt && rt_f == last_ld))) begin
          exp_pcw = 1'b0; m_ctrl = '0; last_ld = 0; stall_left = S - 1;
          if (m_cnt < cmax) m_cnt++;
        end else begin
          exp_pcw = 1'b1;
          m_ctrl  = ref_decode(cur[31:26]);
          last_ld = (cur[31:26] == 6'b100011) ? rt_f : 0;
        end
        comb_q.push_back(exp_pcw);
        prev_pcw = exp_pcw;
      end
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("cfg%0d drain", g), 32'(comb_q.size() + reg_q.size()), 32'd0);
      done = 1'b1;
    end

    always @(negedge clk) begin : monitor
      exp_reg_t r;
      bit       e;
      if (comb_q.size() > 0) begin
        e = comb_q.pop_front();
        check($sformatf("cfg%0d pc_write", g), 32'(pcw), 32'(e));
        check($sformatf("cfg%0d if_id_write", g), 32'(ifw), 32'(e));
      end
      if (reg_q.size() > 0) begin
        r = reg_q.pop_front();
        check($sformatf("cfg%0d ctrl{wb,m,ex,j}", g), 32'({wb, m, ex, jump}), 32'(r.ctrl));
        check($sformatf("cfg%0d bubble_cnt", g), 32'(cnt), r.cnt);
      end
    end
  end

  initial begin : finish_ctl
    int c;
    c = 0;
    while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) && c < 5 * N_CYCLES) begin
      @(posedge clk);
      c++;
    end
    if (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done)) begin
      total++;
      bad++;
      $display("FAIL timeout: drivers done=%0b%0b%0b required 111",
               g_cfg[0].done, g_cfg[1].done, g_cfg[2].done);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
